// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (state encoding, line levels, parity helper) for rx and tx.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam logic START_BIT          = 1'b0;
  localparam logic STOP_BIT           = 1'b1;
  localparam int   DEFAULT_OVERSAMPLE = 16;

  // Even parity over up to 32 payload bits; callers zero-extend narrower data.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose: 2-flop synchronizer bringing an asynchronous line into the clk domain.
// Latency: 2 clk.
// Backpressure: none; samples every clk.
// Ports: clk/rst (async active-high), async_i raw line, sync_o synchronized line.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Purpose: UART receiver (start, DATA_BITS LSB first, optional even parity, stop) at OVERSAMPLE x baud.
// Latency: rx_done 1 clk after the tick sampling the stop bit (OVERSAMPLE/2 + (DATA_BITS+1+PARITY_EN)*OVERSAMPLE ticks after detect).
// Backpressure: none; consumer must take data_out on the rx_done strobe (held until next frame).
// Ports: clk, rst (async active-high), tick (oversample enable), rx (async serial line, idle high),
//        data_out / parity_err / frame_err (held, valid with rx_done), rx_done (1-clk strobe), busy (state != IDLE).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int             TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx),
    .sync_o  (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    data_d     = data_q;
    done_d     = 1'b0;  // strobe clears on its own, tick or not
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (rx_s == START_BIT) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end

        START: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          // Re-check at mid start bit; a high line here is a glitch.
          if (tick_cnt_q == MID_CNT) begin
            if (rx_s == START_BIT) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end

        DATA: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == LAST_CNT) begin
            // LSB arrives first, so shift right and insert at the MSB.
            shift_d    = DATA_BITS'({rx_s, shift_q} >> 1);
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == LAST_CNT) begin
            perr_d     = rx_s ^ even_parity(32'(shift_q));
            tick_cnt_d = '0;
            state_d    = STOP;
          end
        end

        STOP: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == LAST_CNT) begin
            data_d     = shift_q;
            perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
            ferr_d     = (rx_s != STOP_BIT);
            done_d     = 1'b1;
            tick_cnt_d = '0;
            // Returning to IDLE now lets a start bit right after the stop bit be seen.
            state_d    = (rx_s == STOP_BIT) ? IDLE : BREAK;
          end
        end

        BREAK: begin
          // Hold here while the line stays low so a break reports only once.
          if (rx_s == STOP_BIT) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign rx_done    = done_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: directed self-checking bench for uart_rx with hand-computed expectations.
// Latency: tick every 3 clk; line changes take effect on the next tick.
// Backpressure: n/a.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Observation state, updated on the falling edge.
  int         cyc       = 0;
  int         tick_ctr  = 0;
  int         tick_cyc  = 0;
  int         done_cnt  = 0;
  int         done_tick = 0;
  int         done_gap  = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .PARITY_EN  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .data_out   (data_out),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tick === 1'b1) begin
      tick_ctr = tick_ctr + 1;
      tick_cyc = cyc;
    end
    if (rx_done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_tick = tick_ctr;
      done_gap  = cyc - tick_cyc;
      last_data = data_out;
      last_perr = parity_err;
      last_ferr = frame_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One tick: 2 quiet clk (line settles through the synchronizer), then a 1-clk pulse.
  task automatic do_ticks(input int n);
    repeat (n) begin
      repeat (2) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    do_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  initial begin
    int t0;
    int d0;

    rst  = 1'b1;
    tick = 1'b0;
    rx   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_out, 8'h00);
    chk("rst_done", rx_done, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    do_ticks(20);

    // 0xA5: four ones -> parity 0; also pins the 168-tick latency.
    t0 = tick_ctr;
    d0 = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_done_cnt", done_cnt - d0, 1);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_perr", last_perr, 1'b0);
    chk("a5_ferr", last_ferr, 1'b0);
    chk("a5_latency_ticks", done_tick - t0, 169);
    chk("a5_done_gap_clk", done_gap, 1);
    chk("a5_busy_after", busy, 1'b0);

    // 0x01 with wrong parity bit.
    d0 = done_cnt;
    send_frame(8'h01, 1'b0, 1'b1);
    chk("p01_done_cnt", done_cnt - d0, 1);
    chk("p01_data", last_data, 8'h01);
    chk("p01_perr", last_perr, 1'b1);
    chk("p01_ferr", last_ferr, 1'b0);

    // Glitch: low 4 ticks; mid-bit recheck happens 8 ticks after detect.
    d0 = done_cnt;
    rx = 1'b0;
    do_ticks(4);
    chk("glitch_busy_low", busy, 1'b1);
    rx = 1'b1;
    do_ticks(4);
    chk("glitch_busy_pre_mid", busy, 1'b1);
    do_ticks(1);
    chk("glitch_busy_mid", busy, 1'b0);
    do_ticks(20);
    chk("glitch_no_done", done_cnt - d0, 0);
    chk("glitch_data_held", data_out, 8'h01);

    // 0x3C with stop=0, line held low for 40 bit times.
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("brk_done_cnt", done_cnt - d0, 1);
    chk("brk_data", last_data, 8'h3C);
    chk("brk_ferr", last_ferr, 1'b1);
    chk("brk_perr", last_perr, 1'b0);
    do_ticks(640);
    chk("brk_single_done", done_cnt - d0, 1);
    chk("brk_busy_low", busy, 1'b1);
    rx = 1'b1;
    do_ticks(2);
    chk("brk_busy_release", busy, 1'b0);
    do_ticks(14);
    d0 = done_cnt;
    send_frame(8'h81, 1'b0, 1'b1);
    chk("x81_done_cnt", done_cnt - d0, 1);
    chk("x81_data", last_data, 8'h81);
    chk("x81_perr", last_perr, 1'b0);
    chk("x81_ferr", last_ferr, 1'b0);

    // Back-to-back 0x55 then 0xAA, no idle gap.
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    chk("b2b_first_cnt", done_cnt - d0, 1);
    chk("b2b_first_data", last_data, 8'h55);
    send_frame(8'hAA, 1'b0, 1'b1);
    chk("b2b_second_cnt", done_cnt - d0, 2);
    chk("b2b_second_data", last_data, 8'hAA);
    chk("b2b_perr", last_perr, 1'b0);
    chk("b2b_ferr", last_ferr, 1'b0);

    // Reset during data bits of 0xF0 (start + 3 zero data bits sent).
    d0 = done_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_done", rx_done, 1'b0);
    chk("mid_rst_perr", parity_err, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_ticks(200);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_data_after", data_out, 8'h00);
    send_frame(8'h0F, 1'b0, 1'b1);
    chk("x0f_done_cnt", done_cnt - d0, 1);
    chk("x0f_data", last_data, 8'h0F);
    chk("x0f_perr", last_perr, 1'b0);
    chk("x0f_ferr", last_ferr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
